// File: rtl/uart_pkg.sv
// Shared UART transmit-path definitions: arbiter state encoding, default byte width, clog2 helper.
// Pure declarations; no logic, latency or flow control of its own.
package uart_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4
  } arb_state_t;

  // Never returns 0, so widths derived from it stay legal for degenerate parameters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin priority encoder: first set req bit at or after ptr (mod N) wins.
// Purely combinational, zero latency; no flow control.
module rr_select import uart_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [clog2(N)-1:0]   ptr,
  output logic                  valid,
  output logic [clog2(N)-1:0]   winner
);

  localparam int IW = clog2(N);

  logic [IW:0] cand;

  // Scan from the farthest candidate down so the one nearest ptr is written last.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) begin
        cand = cand - (IW + 1)'(N);
      end
      if (req[cand[IW-1:0]]) begin
        valid  = 1'b1;
        winner = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte producers, round-robin, one byte per grant.
// Grant edge -> ack/tx_start next cycle; waits on tx_busy, requests are ignored outside IDLE.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int N            = 4,
  parameter int DW           = UART_DW,
  parameter int BUSY_TIMEOUT = 16,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*DW-1:0]       req_data,
  output logic [N-1:0]          ack,
  output logic                  tx_start,
  output logic [DW-1:0]         tx_data,
  input  logic                  tx_busy,
  output logic [clog2(N)-1:0]   owner,
  output logic                  active,
  output logic                  timeout_err
);

  localparam int IW      = clog2(N);
  localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int CW      = clog2(CNT_MAX + 1);
  // BUSY_TIMEOUT must be at least 2: the LAUNCH cycle counts toward the wait.
  localparam logic [CW-1:0] TO_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  arb_state_t        state_q, state_d;
  logic [N-1:0]      ack_q, ack_d;
  logic              tx_start_q, tx_start_d;
  logic [DW-1:0]     tx_data_q, tx_data_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              sel_valid;
  logic [IW-1:0]     sel_idx;
  logic              grant;
  logic [CW-1:0]     cnt_inc;

  rr_select #(.N(N)) u_rr_select (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (sel_valid),
    .winner (sel_idx)
  );

  assign grant   = (state_q == IDLE) && !tx_busy && sel_valid;
  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (grant) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_inc == TO_LAST) begin
          state_d = IDLE;
        end
      end
      WAIT_DONE: if (!tx_busy) state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (cnt_q == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          ack_d[sel_idx] = 1'b1;
          tx_start_d     = 1'b1;
          tx_data_d      = req_data[sel_idx*DW +: DW];
          owner_d        = sel_idx;
          ptr_d          = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + 1'b1;
        end
      end
      LAUNCH:    cnt_d = '0;
      WAIT_BUSY: begin
        cnt_d = cnt_inc;
        if (!tx_busy && cnt_inc == TO_LAST) begin
          err_d = 1'b1;
        end
      end
      WAIT_DONE: cnt_d = '0;
      GAP:       cnt_d = cnt_inc;
      default:   cnt_d = '0;
    endcase
    active = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign owner       = owner_q;
  assign timeout_err = err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter (`uart_tx_FSM` plus `BaudGen`) among N byte producers, e.g. the ASCII ROM reader, a status reporter and a debug probe. It sits between the producers and the transmitter's `tx_start`/`tx_data`/`tx_busy` handshake. It grants one byte at a time, issues a single-cycle start pulse, tracks the frame through the transmitter's busy flag, and enforces an optional idle gap between frames.

## Interface
Parameters:
- `N`, default 4: number of requesters (2..8).
- `DW`, default 8: data width per requester.
- `BUSY_TIMEOUT`, default 16: maximum clocks to wait for `tx_busy` to rise after `tx_start`.
- `GAP_CYCLES`, default 0: idle clocks inserted after `tx_busy` falls. 0 skips the GAP state.

Ports:
- `clk` input 1: single system clock (PLL output).
- `rst` input 1: reset. One clock; reset is synchronous and active-low.
- `req` input N: per-requester byte request level. Held until its `ack` bit is seen.
- `req_data` input N*DW: packed bytes; requester i occupies bits [i*DW +: DW].
- `ack` output N: one-hot, single-cycle pulse; the byte from requester i has been captured.
- `tx_start` output 1: single-cycle start pulse to the transmitter.
- `tx_data` output DW: registered byte to the transmitter; stable from `tx_start` until return to IDLE.
- `tx_busy` input 1: transmitter busy flag.
- `owner` output clog2(N): index of the last granted requester.
- `active` output 1: high in every state except IDLE.
- `timeout_err` output 1: sticky flag; set on busy timeout, cleared only by reset.

## Operation
FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE**
  - If `tx_busy`=0 and any `req` bit is set, pick the winner by round-robin.
  - Register `tx_data` ← winner's byte, `ack[winner]` ← 1, `owner` ← winner, pointer ← winner+1 mod N.
  - Next state: LAUNCH.
  - If `tx_busy`=1 (foreign or stale frame), stay in IDLE and grant nothing.
- **LAUNCH**
  - `tx_start`=1 for exactly this cycle; `ack` returns to 0.
  - Clear the timeout counter. Next state: WAIT_BUSY.
- **WAIT_BUSY**
  - If `tx_busy`=1, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `BUSY_TIMEOUT`-1, set `timeout_err` and go to IDLE. The byte is dropped and not retried.
- **WAIT_DONE**
  - Stay while `tx_busy`=1.
  - On `tx_busy`=0, go to GAP, or to IDLE if `GAP_CYCLES`=0.
- **GAP**
  - Count `GAP_CYCLES` clocks, then go to IDLE.

Round-robin rule:
- Search order is pointer, pointer+1, …, pointer+N-1 (mod N). The first set `req` bit wins.
- After reset the pointer is 0, so requester 0 has top priority.
- The pointer advances only on a grant.

Reset values: state IDLE; `ack`=0, `tx_start`=0, `tx_data`=0, `owner`=0, `active`=0, `timeout_err`=0, pointer 0, counters 0.

## Timing
- Grant latency: `req` sampled high at edge k (IDLE, `tx_busy`=0) → `ack` and `tx_data` valid after edge k; `tx_start` is high in cycle k+1 only.
- `req_data` is sampled only at the grant edge. It may change from the cycle after `ack`.
- A requester that keeps `req` high after its `ack` is treated as a new request. It competes again in the next IDLE cycle and is subject to rotation.
- Back-to-back frames with `GAP_CYCLES`=0: IDLE is re-entered the cycle after `tx_busy` falls, and the next grant occurs in that cycle.
- Requests that appear or vanish while not in IDLE are ignored. There is no queueing inside the block.
- Synchronous reset in any state returns every output to its reset value at the next edge. `tx_start` must never be asserted in the reset cycle or the cycle after it.
- `tx_start` is never asserted more than once per grant, and `ack` is never asserted without a following `tx_start`.

## Structure
- Shared package `uart_pkg`: state encoding constants (IDLE=0 … GAP=4), default `DW`=8, and the `clog2` function.
- One sub-module, `rr_select`: combinational round-robin priority encoder. Inputs are `req` and pointer; outputs are `valid` and winner index.
- The FSM, counters, pointer register and output registers live in `uart_tx_arbiter`.
- `tx_start` and `ack` are driven directly from flops.

## Test plan
- **Single requester.** `req`=4'b0100, byte 8'h41, busy model rises 2 clocks after `tx_start` and lasts 100 clocks.
  - Expect `ack`=4'b0100 for one cycle, `tx_data`=8'h41, one `tx_start` pulse and `owner`=2.
  - Expect IDLE 1 clock after busy falls.
- **Fairness.** `req`=4'b1111 held, bytes 8'h30..8'h33.
  - Grant order must be 0,1,2,3,0,…; 8 frames yield exactly 2 acks per requester.
- **Gap.** `GAP_CYCLES`=5, two requesters.
  - Expect exactly 5 idle clocks between busy falling and the second `tx_start` plus 1.
- **Busy timeout.** `BUSY_TIMEOUT`=16 and `tx_busy` stuck at 0.
  - Expect `timeout_err` set 16 clocks after `tx_start` and return to IDLE.
  - Expect the next request still served and `timeout_err` remaining 1 until reset.
- **Foreign busy.** `tx_busy`=1 in IDLE with `req`=4'b0001.
  - Expect no `ack` until busy drops, then a grant in the same cycle busy is seen low.
- **Reset mid-frame.** Assert `rst`=0 in WAIT_DONE.
  - Expect all outputs at reset values next edge and pointer at 0.
  - After release with `req`=4'b1010, requester 1 wins first.
